// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit
//   Producer side of the register-file write port. ALU and load results
//   are accepted through valid/ready, held in a small in-order FIFO, and
//   retired one per cycle when the write port is not stalled. Decode can
//   query whether a register has a write that has not yet retired.
//   Optional feature macro: WB_FWD_EN (forward youngest pending value).
module reg_writeback_unit #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_W-1:0]             alu_addr,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          wb_stall,
  output logic                          rf_write,
  output logic [ADDR_W-1:0]             rf_write_addr,
  output logic [DATA_W-1:0]             rf_write_data,
  input  logic [ADDR_W-1:0]             rd_addr1,
  input  logic [ADDR_W-1:0]             rd_addr2,
  output logic                          rd_pending1,
  output logic                          rd_pending2,
  output logic [DATA_W-1:0]             fwd_data1,
  output logic [DATA_W-1:0]             fwd_data2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // FIFO storage; no reset needed because occupancy is tracked by r_count
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rf_write;
  logic [ADDR_W-1:0] r_rf_write_addr;
  logic [DATA_W-1:0] r_rf_write_data;

  logic              w_full;
  logic              w_empty;
  logic              w_mem_acc;
  logic              w_alu_acc;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_push_addr;
  logic [DATA_W-1:0] w_push_data;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Load path wins the single enqueue slot (it is the older instruction).
  // Ready never looks at wb_stall, so a full FIFO refuses even while draining.
  assign mem_ready = !rst && !w_full;
  assign alu_ready = !rst && !w_full && !mem_valid;

  assign w_mem_acc   = mem_valid && mem_ready;
  assign w_alu_acc   = alu_valid && alu_ready;
  assign w_push_addr = w_mem_acc ? mem_addr : alu_addr;
  assign w_push_data = w_mem_acc ? mem_data : alu_data;
  // Writes to r0 complete the handshake but are discarded
  assign w_push      = (w_mem_acc || w_alu_acc) && (w_push_addr != '0);
  assign w_pop       = !w_empty && !wb_stall;

  assign rf_write      = r_rf_write;
  assign rf_write_addr = r_rf_write_addr;
  assign rf_write_data = r_rf_write_data;
  assign fifo_count    = r_count;

  // Store accepted results at the tail slot
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= w_push_addr;
      r_fifo_data[r_wr_ptr] <= w_push_data;
    end
  end

  // Pointers, occupancy and the register-file output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_rf_write      <= 1'b0;
      r_rf_write_addr <= '0;
      r_rf_write_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      r_rf_write <= w_pop;
      if (w_pop) begin
        r_rf_write_addr <= r_fifo_addr[r_rd_ptr];
        r_rf_write_data <= r_fifo_data[r_rd_ptr];
      end
    end
  end

  // One lookup per decode read port
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
      logic [ADDR_W-1:0] w_addr;
      logic              w_hit;
      assign w_addr = (gi == 0) ? rd_addr1 : rd_addr2;

`ifdef WB_FWD_EN
      logic [DATA_W-1:0] w_val;
`endif

      // Scan output stage first, then FIFO oldest to youngest so the
      // youngest match is the value left standing
      always_comb begin
        w_hit = 1'b0;
`ifdef WB_FWD_EN
        w_val = '0;
`endif
        if (r_rf_write && (r_rf_write_addr == w_addr)) begin
          w_hit = 1'b1;
`ifdef WB_FWD_EN
          w_val = r_rf_write_data;
`endif
        end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
          if ((CNT_W'(k) < r_count) &&
              (r_fifo_addr[r_rd_ptr + PTR_W'(k)] == w_addr)) begin
            w_hit = 1'b1;
`ifdef WB_FWD_EN
            w_val = r_fifo_data[r_rd_ptr + PTR_W'(k)];
`endif
          end
        end
        if (w_addr == '0) begin
          w_hit = 1'b0;
`ifdef WB_FWD_EN
          w_val = '0;
`endif
        end
      end

      if (gi == 0) begin : g_p1
        assign rd_pending1 = w_hit;
`ifdef WB_FWD_EN
        assign fwd_data1 = w_val;
`else
        assign fwd_data1 = '0;
`endif
      end else begin : g_p2
        assign rd_pending2 = w_hit;
`ifdef WB_FWD_EN
        assign fwd_data2 = w_val;
`else
        assign fwd_data2 = '0;
`endif
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with a write-back scoreboard.
module tb_reg_writeback_unit;

  localparam int DW = 16;
  localparam int AW = 3;
`ifdef WB_FWD_EN
  localparam logic [DW-1:0] FWD_R5 = 16'h0002;
`else
  localparam logic [DW-1:0] FWD_R5 = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, mem_ready, alu_valid, alu_ready, wb_stall;
  logic [AW-1:0] mem_addr, alu_addr, rf_write_addr, rd_addr1, rd_addr2;
  logic [DW-1:0] mem_data, alu_data, rf_write_data, fwd_data1, fwd_data2;
  logic          rf_write, rd_pending1, rd_pending2;
  logic [2:0]    fifo_count;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] sb [$];

  always #5 clk = ~clk;

  reg_writeback_unit dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .wb_stall(wb_stall),
    .rf_write(rf_write), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_pending1(rd_pending1), .rd_pending2(rd_pending2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then compare any retiring write
  task automatic drive(input logic r, input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad, input logic st);
    logic [AW+DW-1:0] exp;
    @(negedge clk);
    rst = r; mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad; wb_stall = st;
    #1;
    if (rf_write === 1'b1) begin
      $display("wb   addr=%0d data=0x%04h", rf_write_addr, rf_write_data);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=addr%0d expected=none", rf_write_addr);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("wb_addr", 32'(rf_write_addr), 32'(exp[AW+DW-1:DW]));
        chk("wb_data", 32'(rf_write_data), 32'(exp[DW-1:0]));
      end
    end
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, st);
  endtask

  // Check a ready and, when the bench expects acceptance, schedule the write
  task automatic accept(input string tag, input logic obs_ready, input logic exp_ready,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk(tag, 32'(obs_ready), 32'(exp_ready));
    if (exp_ready && (a != '0)) begin
      sb.push_back({a, d});
      $display("push addr=%0d data=0x%04h", a, d);
    end
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0; wb_stall = 1'b0;
    mem_addr = '0; mem_data = '0; alu_addr = '0; alu_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;

    // Reset: readys low even with valid offered, outputs cleared
    drive(1'b1, 1'b1, 3'd3, 16'h1234, 1'b1, 3'd2, 16'h4321, 1'b0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    drive(1'b1, 1'b1, 3'd3, 16'h1234, 1'b1, 3'd2, 16'h4321, 1'b0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_rf_write", 32'(rf_write), 0);
    chk("rst_addr", 32'(rf_write_addr), 0);
    chk("rst_data", 32'(rf_write_data), 0);

    // 1: single load result, two-edge latency
    drive(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, '0, '0, 1'b0);
    accept("t1_mem_ready", mem_ready, 1'b1, 3'd3, 16'h1234);
    idle(1'b0);
    chk("t1_count1", 32'(fifo_count), 1);
    chk("t1_no_write_yet", 32'(rf_write), 0);
    idle(1'b0);
    chk("t1_write", 32'(rf_write), 1);
    chk("t1_count0", 32'(fifo_count), 0);
    idle(1'b0);
    chk("t1_write_done", 32'(rf_write), 0);

    // 2: simultaneous offers, load first
    drive(1'b0, 1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b0);
    accept("t2_mem_ready", mem_ready, 1'b1, 3'd1, 16'hAAAA);
    accept("t2_alu_ready", alu_ready, 1'b0, 3'd2, 16'h5555);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 3'd2, 16'h5555, 1'b0);
    accept("t2_alu_ready2", alu_ready, 1'b1, 3'd2, 16'h5555);
    idle(1'b0);
    chk("t2_first", 32'(rf_write), 1);
    idle(1'b0);
    chk("t2_second", 32'(rf_write), 1);
    idle(1'b0);
    chk("t2_drained", 32'(sb.size()), 0);

    // 3: fill under stall, then drain back-to-back
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 3'(i), 16'(16'h1110 * i), 1'b1);
      accept("t3_alu_ready", alu_ready, 1'b1, 3'(i), 16'(16'h1110 * i));
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 3'd5, 16'h9999, 1'b1);
    chk("t3_count_full", 32'(fifo_count), 4);
    accept("t3_full_alu_ready", alu_ready, 1'b0, 3'd5, 16'h9999);
    chk("t3_full_mem_ready", 32'(mem_ready), 0);
    chk("t3_stall_no_write", 32'(rf_write), 0);
    idle(1'b0);
    chk("t3_full_still", 32'(fifo_count), 4);
    chk("t3_full_mem_ready2", 32'(mem_ready), 0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("t3_b2b_write", 32'(rf_write), 1);
    end
    idle(1'b0);
    chk("t3_end_write", 32'(rf_write), 0);
    chk("t3_end_count", 32'(fifo_count), 0);

    // 4: write to r0 is accepted and dropped
    rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 3'd0, 16'hFFFF, 1'b0);
    accept("t4_alu_ready", alu_ready, 1'b1, 3'd0, 16'hFFFF);
    idle(1'b0);
    chk("t4_count", 32'(fifo_count), 0);
    chk("t4_pending_r0", 32'(rd_pending1), 0);
    idle(1'b0);
    chk("t4_no_write", 32'(rf_write), 0);

    // 5: two pending writes to r5, youngest forwarded
    rd_addr1 = 3'd5; rd_addr2 = 3'd3;
    drive(1'b0, 1'b1, 3'd5, 16'h0001, 1'b0, '0, '0, 1'b1);
    accept("t5_push1", mem_ready, 1'b1, 3'd5, 16'h0001);
    drive(1'b0, 1'b1, 3'd5, 16'h0002, 1'b0, '0, '0, 1'b1);
    accept("t5_push2", mem_ready, 1'b1, 3'd5, 16'h0002);
    idle(1'b1);
    chk("t5_pending1", 32'(rd_pending1), 1);
    chk("t5_pending2", 32'(rd_pending2), 0);
    chk("t5_fwd1", 32'(fwd_data1), 32'(FWD_R5));
    chk("t5_fwd2", 32'(fwd_data2), 0);
    idle(1'b0);
    idle(1'b0);
    chk("t5_pend_mixed", 32'(rd_pending1), 1);
    chk("t5_fwd_mixed", 32'(fwd_data1), 32'(FWD_R5));
    idle(1'b0);
    chk("t5_pend_outstage", 32'(rd_pending1), 1);
    chk("t5_fwd_outstage", 32'(fwd_data1), 32'(FWD_R5));
    idle(1'b0);
    chk("t5_pend_clear", 32'(rd_pending1), 0);
    chk("t5_fwd_clear", 32'(fwd_data1), 0);

    // 6: reset discards buffered results
    rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 3'(i), 16'(16'h0100 + i), 1'b1);
      accept("t6_alu_ready", alu_ready, 1'b1, 3'(i), 16'(16'h0100 + i));
    end
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    chk("t6_count3", 32'(fifo_count), 3);
    sb.delete();
    idle(1'b0);
    chk("t6_count0", 32'(fifo_count), 0);
    chk("t6_rf_write", 32'(rf_write), 0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    chk("t6_still_empty", 32'(fifo_count), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
